vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 The module SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The module SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, vertical front porch, sync and back porch in lines.
REQ-007 The module SHALL have parameter SYNC_POL, default 0; 0 = sync pulses active-low, 1 = active-high.
REQ-008 The module SHALL have parameter CW, default 10, counter and coordinate width.
REQ-009 The module SHALL have port clk_in, input, 1 bit, system clock.
REQ-010 The module SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-011 The module SHALL have port pix_en, input, 1 bit, pixel strobe from the upstream clock divider; one pixel per clk_in cycle with pix_en=1.
REQ-012 The module SHALL have ports hsync and vsync, outputs, 1 bit each, sync pulses with polarity set by SYNC_POL.
REQ-013 The module SHALL have port video_on, output, 1 bit, high while the current pixel is inside the active area.
REQ-014 The module SHALL have ports x and y, outputs, CW bits each, current horizontal and vertical count.
REQ-015 The module SHALL have ports frame_start and line_end, outputs, 1 bit each, single-clk_in-cycle pulses.

Function
REQ-016 The module SHALL hold an internal horizontal count hc and vertical count vc; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-017 Each axis SHALL track its phase: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, changing phase when the count crosses each region boundary.
REQ-018 On a cycle with pix_en=1, all outputs SHALL register the decode of the current (hc,vc); hc SHALL then increment.
REQ-019 hc SHALL wrap from H_TOTAL-1 to 0 and increment vc at the same time; vc SHALL wrap from V_TOTAL-1 to 0 on that same strobe.
REQ-020 On a cycle with pix_en=0, counts and the registered hsync, vsync, video_on, x and y SHALL hold, and frame_start and line_end SHALL be 0.
REQ-021 Registered values SHALL be: x=hc, y=vc, video_on=(hc<H_ACTIVE && vc<V_ACTIVE), hsync active when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], vsync active when vc is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-022 frame_start SHALL be 1 for exactly one clk_in cycle when (hc,vc)=(0,0) is registered; line_end SHALL likewise pulse when hc=H_TOTAL-1 is registered.
REQ-023 pix_en held continuously high SHALL be legal, giving one pixel per clk_in cycle.
REQ-024 Total output latency SHALL be one clk_in cycle after the pix_en strobe.

Reset
REQ-025 When rst=0 at a clk_in rising edge, hc, vc and both phases SHALL be set to 0 and ACTIVE, regardless of pix_en.
REQ-026 Under reset, hsync and vsync SHALL be at the inactive level (=~SYNC_POL), video_on, frame_start and line_end SHALL be 0, and x and y SHALL be 0.
REQ-027 The first pix_en strobe after reset SHALL register pixel (0,0) and raise frame_start.

Structure
REQ-028 Package vga_pkg SHALL hold the phase enum (ACTIVE, FRONT, SYNC, BACK) and the default 640x480@60 timing constants.
REQ-029 Sub-module vga_axis_counter (count, phase, wrap flag, sync decode) SHALL be instantiated twice, horizontal and vertical; the vertical instance advances on the horizontal wrap.

Verification
REQ-030 Reset, then pix_en every 4th cycle -> first strobe gives x=0, y=0, video_on=1, vsync and hsync inactive, and frame_start high for exactly 1 cycle.
REQ-031 Run one line -> video_on falls at x=640; hsync is low for exactly 96 strobes, x=656..751; line_end pulses at x=799; the next strobe gives x=0, y=1.
REQ-032 Run a full frame -> vsync is low only for y=490..491 (1600 strobes); frame_start period is 420000 strobes.
REQ-033 Hold pix_en=0 for 50 cycles at x=300 -> all outputs stable, no pulses; resume at x=301.
REQ-034 Pull rst low for 1 cycle at (x=700, y=300) -> next cycle shows the REQ-026 values; the next strobe gives (0,0) and frame_start.
REQ-035 With SYNC_POL=1 -> hsync is high at x=656..751 and low elsewhere, including under reset.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA timing generator.
//   phase_e       : region of a scan axis (active, front porch, sync, back porch)
//   DEF_*         : default 640x480@60 timing (25.175 MHz pixel clock)
//   axisTotal()   : total length of one axis in pixels or lines
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CW       = 10;

   function automatic int axisTotal(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// Bundles the pixel strobe and the registered timing outputs of vga_timing.
//   pix_en      : pixel strobe from the upstream clock divider
//   hsync/vsync : sync pulses, polarity chosen by the generator
//   video_on    : current pixel lies in the visible area
//   x, y        : current pixel coordinates
//   frame_start : one-cycle pulse when pixel (0,0) is presented
//   line_end    : one-cycle pulse when the last pixel of a line is presented
// master = timing generator, slave = downstream pixel consumer.
// -----------------------------------------------------------------------------
interface vga_if #(
   parameter int CW = 10
) ();

   logic          pix_en;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          frame_start;
   logic          line_end;

   modport master (
      input  pix_en,
      output hsync, vsync, video_on, x, y, frame_start, line_end
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, video_on, x, y, frame_start, line_end
   );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One scan axis (horizontal or vertical): a wrapping position counter plus a
// small FSM that tracks which region (ACTIVE/FRONT/SYNC/BACK) the count is in.
//   clk_in    : system clock
//   rst       : synchronous active-low reset
//   adv_i     : advance the count by one this cycle
//   count_o   : current position on the axis
//   wrap_o    : count is at the last position (next advance returns to 0)
//   sync_o    : count lies inside the sync pulse region
//   active_o  : count lies inside the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int FP_LEN     = DEF_H_FP,
   parameter int SYNC_LEN   = DEF_H_SYNC,
   parameter int BP_LEN     = DEF_H_BP,
   parameter int CW         = DEF_CW
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          adv_i,
   output logic [CW-1:0] count_o,
   output logic          wrap_o,
   output logic          sync_o,
   output logic          active_o
);

   localparam int TOTAL = axisTotal(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

   // Last position of each region; the phase moves on when the count leaves it.
   localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE_LEN - 1);
   localparam logic [CW-1:0] LAST_FRONT  = CW'(ACTIVE_LEN + FP_LEN - 1);
   localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
   localparam logic [CW-1:0] LAST_TOTAL  = CW'(TOTAL - 1);

   logic [CW-1:0] count_q, count_d;
   phase_e        phase_q, phase_d;
   logic          atEnd;

   assign atEnd = (count_q == LAST_TOTAL);

   // Position counter: steps on every advance, returning to zero after the
   // last position of the axis.
   always_comb begin
      count_d = count_q;
      if (adv_i) begin
         count_d = atEnd ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Phase state register.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         phase_q <= ACTIVE;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Phase next-state: move to the following region on the advance that
   // leaves the last position of the current one.
   always_comb begin
      phase_d = phase_q;
      if (adv_i) begin
         case (phase_q)
            ACTIVE:  if (count_q == LAST_ACTIVE) phase_d = FRONT;
            FRONT:   if (count_q == LAST_FRONT)  phase_d = SYNC;
            SYNC:    if (count_q == LAST_SYNC)   phase_d = BACK;
            BACK:    if (atEnd)                  phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
   end

   // Phase outputs: region decodes come straight from the state so the top
   // level never needs its own range comparators.
   always_comb begin
      count_o  = count_q;
      wrap_o   = atEnd;
      sync_o   = (phase_q == SYNC);
      active_o = (phase_q == ACTIVE);
   end

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// VGA raster timing generator. Advances one pixel per clk_in cycle with
// pix_en high and presents the decode of that pixel one cycle later.
//   clk_in : system clock
//   rst    : synchronous active-low reset
//   bus    : vga_if.master -- pix_en in; hsync, vsync, video_on, x, y,
//            frame_start, line_end out (all registered)
// Parameters set the per-axis region lengths, sync polarity (SYNC_POL=1 means
// active-high pulses) and the coordinate width CW.
// -----------------------------------------------------------------------------
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int CW       = DEF_CW
) (
   input  logic  clk_in,
   input  logic  rst,
   vga_if.master bus
);

   logic [CW-1:0] hc, vc;
   logic          hWrap, vWrap;
   logic          hSyncAct, vSyncAct;
   logic          hActive, vActive;
   logic          vAdv;

   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic          frame_start_q, frame_start_d;
   logic          line_end_q, line_end_d;
   logic          atOrigin_q, atOrigin_d;

   // The vertical axis only moves on the strobe that finishes a line.
   assign vAdv = bus.pix_en & hWrap;

   vga_axis_counter #(
      .ACTIVE_LEN (H_ACTIVE),
      .FP_LEN     (H_FP),
      .SYNC_LEN   (H_SYNC),
      .BP_LEN     (H_BP),
      .CW         (CW)
   ) u_hAxis (
      .clk_in   (clk_in),
      .rst      (rst),
      .adv_i    (bus.pix_en),
      .count_o  (hc),
      .wrap_o   (hWrap),
      .sync_o   (hSyncAct),
      .active_o (hActive)
   );

   vga_axis_counter #(
      .ACTIVE_LEN (V_ACTIVE),
      .FP_LEN     (V_FP),
      .SYNC_LEN   (V_SYNC),
      .BP_LEN     (V_BP),
      .CW         (CW)
   ) u_vAxis (
      .clk_in   (clk_in),
      .rst      (rst),
      .adv_i    (vAdv),
      .count_o  (vc),
      .wrap_o   (vWrap),
      .sync_o   (vSyncAct),
      .active_o (vActive)
   );

   // Output decode. atOrigin_q remembers that the counters sit at (0,0):
   // true after reset and after the strobe that wraps both axes, which saves
   // a full-width compare of both counts for frame_start.
   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      x_d           = x_q;
      y_d           = y_q;
      atOrigin_d    = atOrigin_q;
      frame_start_d = 1'b0;
      line_end_d    = 1'b0;
      if (bus.pix_en) begin
         hsync_d       = hSyncAct ? SYNC_POL : ~SYNC_POL;
         vsync_d       = vSyncAct ? SYNC_POL : ~SYNC_POL;
         video_on_d    = hActive & vActive;
         x_d           = hc;
         y_d           = vc;
         frame_start_d = atOrigin_q;
         line_end_d    = hWrap;
         atOrigin_d    = hWrap & vWrap;
      end
   end

   // Output registers; reset parks the syncs at their inactive level.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         line_end_q    <= 1'b0;
         atOrigin_q    <= 1'b1;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         line_end_q    <= line_end_d;
         atOrigin_q    <= atOrigin_d;
      end
   end

   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.video_on    = video_on_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.frame_start = frame_start_q;
   assign bus.line_end    = line_end_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Drives two generators from the same clk/rst/pix_en: dutD with the default
// 640x480 timing and active-low syncs, dutS with a tiny 23x13 raster and
// active-high syncs so whole frames are cheap to run.
// -----------------------------------------------------------------------------
module tb_vga_timing;

   typedef struct {
      int hAct, hFp, hSync, hBp, vAct, vFp, vSync, vBp;
      int pol;
   } cfg_t;

   typedef struct {
      int hs, vs, von, fs, le, x, y;
   } obs_t;

   typedef struct {
      logic r, p;
      int   hs, vs, von, fs, le, x, y;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pixEn = 1'b0;

   int nTests = 0;
   int nFail  = 0;

   cfg_t cfg[2];
   int   mh[2];
   int   mv[2];
   obs_t me[2];

   vga_if #(.CW(10)) ifD ();
   vga_if #(.CW(10)) ifS ();

   assign ifD.pix_en = pixEn;
   assign ifS.pix_en = pixEn;

   vga_timing dutD (
      .clk_in (clk),
      .rst    (rst),
      .bus    (ifD)
   );

   vga_timing #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
      .SYNC_POL (1'b1), .CW (10)
   ) dutS (
      .clk_in (clk),
      .rst    (rst),
      .bus    (ifS)
   );

   always #5 clk = ~clk;

   // Reference model: raster position as plain integers, outputs derived
   // from the region arithmetic of each axis.
   function automatic void modelStep(input int k, input logic r, input logic p);
      int hTot, vTot, hsLo, vsLo;
      hTot = cfg[k].hAct + cfg[k].hFp + cfg[k].hSync + cfg[k].hBp;
      vTot = cfg[k].vAct + cfg[k].vFp + cfg[k].vSync + cfg[k].vBp;
      hsLo = cfg[k].hAct + cfg[k].hFp;
      vsLo = cfg[k].vAct + cfg[k].vFp;
      if (!r) begin
         mh[k] = 0;
         mv[k] = 0;
         me[k].hs = 1 - cfg[k].pol;
         me[k].vs = 1 - cfg[k].pol;
         me[k].von = 0; me[k].fs = 0; me[k].le = 0; me[k].x = 0; me[k].y = 0;
      end else if (p) begin
         me[k].x   = mh[k];
         me[k].y   = mv[k];
         me[k].von = (mh[k] < cfg[k].hAct && mv[k] < cfg[k].vAct) ? 1 : 0;
         me[k].hs  = (mh[k] >= hsLo && mh[k] < hsLo + cfg[k].hSync) ? cfg[k].pol : 1 - cfg[k].pol;
         me[k].vs  = (mv[k] >= vsLo && mv[k] < vsLo + cfg[k].vSync) ? cfg[k].pol : 1 - cfg[k].pol;
         me[k].fs  = (mh[k] == 0 && mv[k] == 0) ? 1 : 0;
         me[k].le  = (mh[k] == hTot - 1) ? 1 : 0;
         mh[k]++;
         if (mh[k] == hTot) begin
            mh[k] = 0;
            mv[k]++;
            if (mv[k] == vTot) mv[k] = 0;
         end
      end else begin
         me[k].fs = 0;
         me[k].le = 0;
      end
   endfunction

   function automatic obs_t readDut(input int k);
      obs_t o;
      if (k == 0) begin
         o.hs = int'(ifD.hsync); o.vs = int'(ifD.vsync); o.von = int'(ifD.video_on);
         o.fs = int'(ifD.frame_start); o.le = int'(ifD.line_end);
         o.x = int'(ifD.x); o.y = int'(ifD.y);
      end else begin
         o.hs = int'(ifS.hsync); o.vs = int'(ifS.vsync); o.von = int'(ifS.video_on);
         o.fs = int'(ifS.frame_start); o.le = int'(ifS.line_end);
         o.x = int'(ifS.x); o.y = int'(ifS.y);
      end
      return o;
   endfunction

   function automatic void cmp(input string name, input int act, input int exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic checkOutput(input int k);
      obs_t a;
      string t;
      a = readDut(k);
      t = (k == 0) ? "D" : "S";
      cmp({t, ".hsync"},       a.hs,  me[k].hs);
      cmp({t, ".vsync"},       a.vs,  me[k].vs);
      cmp({t, ".video_on"},    a.von, me[k].von);
      cmp({t, ".frame_start"}, a.fs,  me[k].fs);
      cmp({t, ".line_end"},    a.le,  me[k].le);
      cmp({t, ".x"},           a.x,   me[k].x);
      cmp({t, ".y"},           a.y,   me[k].y);
   endtask

   // One clock: inputs change just after the falling edge, outputs are
   // checked against the model at the next falling edge.
   task automatic applyStimulus(input logic r, input logic p);
      rst   = r;
      pixEn = p;
      @(posedge clk);
      modelStep(0, r, p);
      modelStep(1, r, p);
      @(negedge clk);
      checkOutput(0);
      checkOutput(1);
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t  tbl[10];
      obs_t  a;
      int    hsCnt, hsMin, hsMax, vonFall, leCnt, leX, steps;
      int    fsCnt, fsIdx, vsCnt, vsMin, vsMax, shCnt, shMin, shMax;

      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
      cfg[1] = '{16, 2, 3, 2, 8, 1, 2, 2, 1};
      for (int k = 0; k < 2; k++) begin
         mh[k] = 0; mv[k] = 0;
         me[k] = '{0, 0, 0, 0, 0, 0, 0};
      end

      // Reset, then a strobe every 4th cycle (dutD expectations).
      //          r     p     hs vs von fs le x  y
      tbl[0] = '{1'b0, 1'b1, 1, 1, 0,  0, 0, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 1, 1, 1,  1, 0, 0, 0};
      tbl[2] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 0, 0};
      tbl[3] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 0, 0};
      tbl[5] = '{1'b1, 1'b1, 1, 1, 1,  0, 0, 1, 0};
      tbl[6] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 1, 0};
      tbl[7] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 1, 0};
      tbl[8] = '{1'b1, 1'b0, 1, 1, 1,  0, 0, 1, 0};
      tbl[9] = '{1'b1, 1'b1, 1, 1, 1,  0, 0, 2, 0};

      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].r, tbl[i].p);
         a = readDut(0);
         cmp($sformatf("vec%0d.hsync", i),       a.hs,  tbl[i].hs);
         cmp($sformatf("vec%0d.vsync", i),       a.vs,  tbl[i].vs);
         cmp($sformatf("vec%0d.video_on", i),    a.von, tbl[i].von);
         cmp($sformatf("vec%0d.frame_start", i), a.fs,  tbl[i].fs);
         cmp($sformatf("vec%0d.line_end", i),    a.le,  tbl[i].le);
         cmp($sformatf("vec%0d.x", i),           a.x,   tbl[i].x);
         cmp($sformatf("vec%0d.y", i),           a.y,   tbl[i].y);
         if (i == 0) cmp("S reset hsync low", int'(ifS.hsync), 0);
      end

      // One full line on dutD with pix_en held high.
      applyStimulus(1'b0, 1'b0);
      hsCnt = 0; hsMin = 9999; hsMax = -1; vonFall = -1; leCnt = 0; leX = -1;
      for (int i = 0; i < 800; i++) begin
         applyStimulus(1'b1, 1'b1);
         a = readDut(0);
         if (a.hs == 0) begin
            hsCnt++;
            if (a.x < hsMin) hsMin = a.x;
            if (a.x > hsMax) hsMax = a.x;
         end
         if (a.von == 0 && vonFall < 0) vonFall = a.x;
         if (a.le == 1) begin
            leCnt++;
            leX = a.x;
         end
      end
      cmp("line video_on fall x", vonFall, 640);
      cmp("line hsync low count", hsCnt, 96);
      cmp("line hsync first x", hsMin, 656);
      cmp("line hsync last x", hsMax, 751);
      cmp("line line_end count", leCnt, 1);
      cmp("line line_end x", leX, 799);
      applyStimulus(1'b1, 1'b1);
      cmp("next line x", int'(ifD.x), 0);
      cmp("next line y", int'(ifD.y), 1);

      // Hold pix_en low for 50 cycles at x=300.
      steps = 0;
      while (int'(ifD.x) != 300 && steps < 900) begin
         applyStimulus(1'b1, 1'b1);
         steps++;
      end
      cmp("reach x=300", int'(ifD.x), 300);
      for (int i = 0; i < 50; i++) begin
         applyStimulus(1'b1, 1'b0);
         a = readDut(0);
         cmp("hold x", a.x, 300);
         cmp("hold y", a.y, 1);
         cmp("hold video_on", a.von, 1);
         cmp("hold hsync", a.hs, 1);
         cmp("hold frame_start", a.fs, 0);
         cmp("hold line_end", a.le, 0);
      end
      applyStimulus(1'b1, 1'b1);
      cmp("resume x", int'(ifD.x), 301);

      // Reset in the middle of a line at x=700.
      steps = 0;
      while (int'(ifD.x) != 700 && steps < 900) begin
         applyStimulus(1'b1, 1'b1);
         steps++;
      end
      cmp("reach x=700", int'(ifD.x), 700);
      applyStimulus(1'b0, 1'b1);
      a = readDut(0);
      cmp("midreset hsync", a.hs, 1);
      cmp("midreset vsync", a.vs, 1);
      cmp("midreset video_on", a.von, 0);
      cmp("midreset frame_start", a.fs, 0);
      cmp("midreset line_end", a.le, 0);
      cmp("midreset x", a.x, 0);
      cmp("midreset y", a.y, 0);
      applyStimulus(1'b1, 1'b1);
      cmp("post reset x", int'(ifD.x), 0);
      cmp("post reset y", int'(ifD.y), 0);
      cmp("post reset frame_start", int'(ifD.frame_start), 1);

      // Frame-level checks on the small active-high raster (23 x 13 = 299).
      fsCnt = 0; fsIdx = -1; vsCnt = 0; vsMin = 9999; vsMax = -1;
      shCnt = 0; shMin = 9999; shMax = -1;
      for (int i = 1; i < 598; i++) begin
         applyStimulus(1'b1, 1'b1);
         a = readDut(1);
         if (a.fs == 1) begin
            fsCnt++;
            if (fsIdx < 0) fsIdx = i;
         end
         if (i < 299 && a.vs == 1) begin
            vsCnt++;
            if (a.y < vsMin) vsMin = a.y;
            if (a.y > vsMax) vsMax = a.y;
         end
         if (i < 23 && a.hs == 1) begin
            shCnt++;
            if (a.x < shMin) shMin = a.x;
            if (a.x > shMax) shMax = a.x;
         end
      end
      cmp("S frame_start count", fsCnt, 1);
      cmp("S frame_start period", fsIdx, 299);
      cmp("S vsync active strobes", vsCnt, 46);
      cmp("S vsync first y", vsMin, 9);
      cmp("S vsync last y", vsMax, 10);
      cmp("S hsync high count", shCnt, 3);
      cmp("S hsync first x", shMin, 18);
      cmp("S hsync last x", shMax, 20);

      // Randomized strobes with occasional resets, checked by the model.
      for (int i = 0; i < 20000; i++) begin
         applyStimulus(($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1,
                       ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
